byte_bank_ctrl: RTL and testbench

Controller that shares a bank of DEPTH level-sensitive byte cells between two requesters, A and B.
- Arbitrates requests round-robin.
- Sequences each write as a setup/strobe/hold pulse on the selected cell's store input, so data is stable on both edges of store.
- Serves reads by registering the selected cell's output.
- Sits between the week-9 datapath requesters and the byte-cell array; the cells stay outside this block.

---
 rtl/byte_bank_ctrl.sv | 142 ++++++++++++++
 tb/tb_byte_bank_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/byte_bank_ctrl.sv
// -----------------------------------------------------------------------------
// byte_bank_ctrl
//   Shares a bank of DEPTH level-sensitive byte cells between two requesters
//   (A and B). Requests are arbitrated round-robin in IDLE. A write is
//   sequenced as setup/strobe/hold so mem_data is stable on both edges of the
//   one-hot store pulse. A read registers the selected cell output into the
//   owner's rdata. The byte cells themselves live outside this block.
//
//   Handshake: req_x is a level held by the requester until it sees ack_x.
//   gnt_x is high from the cycle after the grant edge through the ack cycle.
//   ack_x is a single-cycle completion pulse. A req still high in the IDLE
//   cycle after ack is a new transaction. Requests are only looked at in IDLE.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   req_a/b, we_a/b       request level and write(1)/read(0) select
//   addr_a/b, wdata_a/b   cell index and write byte, sampled at grant
//   gnt_a/b, ack_a/b      grant (whole transaction) and completion pulse
//   rdata_a/b             last read result per port
//   mem_data, mem_store   byte and one-hot store strobes to the cell array
//   mem_q                 concatenated cell outputs, cell i at [8*i+7:8*i]
//   busy                  high whenever the FSM is not IDLE
//   state_dbg             current FSM state encoding
// -----------------------------------------------------------------------------
module byte_bank_ctrl #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_a,
   input  logic                 req_b,
   input  logic                 we_a,
   input  logic                 we_b,
   input  logic [ADDR_W-1:0]    addr_a,
   input  logic [ADDR_W-1:0]    addr_b,
   input  logic [7:0]           wdata_a,
   input  logic [7:0]           wdata_b,
   output logic                 gnt_a,
   output logic                 gnt_b,
   output logic                 ack_a,
   output logic                 ack_b,
   output logic [7:0]           rdata_a,
   output logic [7:0]           rdata_b,
   output logic [7:0]           mem_data,
   output logic [DEPTH-1:0]     mem_store,
   input  logic [8*DEPTH-1:0]   mem_q,
   output logic                 busy,
   output logic [2:0]           state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      READ   = 3'd4,
      ACK    = 3'd5
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic                owner_b;
   logic                last_b;
   logic [ADDR_W-1:0]   addr_r;
   logic [7:0]          wdata_r;
   logic                grant;
   logic                grant_b;
   logic [7:0]          rd_byte;

   // Round-robin: on a tie, serve the port that was not granted last.
   assign grant   = req_a | req_b;
   assign grant_b = req_b & (~req_a | ~last_b);

   // Selected cell output; addr_r * 8 formed by concatenation.
   assign rd_byte = mem_q[{addr_r, 3'b000} +: 8];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            // The write/read choice is carried by the state itself, so the
            // owner's we needs no register of its own.
            if (grant) begin
               if (grant_b ? we_b : we_a) state_nx = SETUP;
               else                       state_nx = READ;
            end
         end
         SETUP:   state_nx = STROBE;
         STROBE:  state_nx = HOLD;
         HOLD:    state_nx = ACK;
         READ:    state_nx = ACK;
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_b <= 1'b0;
         last_b  <= 1'b1;
         addr_r  <= '0;
         wdata_r <= '0;
      end else if (state == IDLE && grant) begin
         owner_b <= grant_b;
         last_b  <= grant_b;
         addr_r  <= grant_b ? addr_b  : addr_a;
         wdata_r <= grant_b ? wdata_b : wdata_a;
      end
   end

   // Read result is captured on the READ->ACK edge; the other port keeps its value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else if (state == READ) begin
         if (owner_b) rdata_b <= rd_byte;
         else         rdata_a <= rd_byte;
      end
   end

   // All outputs decode from registered state only.
   always_comb begin
      busy      = (state != IDLE);
      gnt_a     = busy & ~owner_b;
      gnt_b     = busy &  owner_b;
      ack_a     = (state == ACK) & ~owner_b;
      ack_b     = (state == ACK) &  owner_b;
      mem_data  = '0;
      mem_store = '0;
      if (state == SETUP || state == STROBE || state == HOLD) mem_data = wdata_r;
      if (state == STROBE) mem_store = DEPTH'(1) << addr_r;
      state_dbg = state;
   end

endmodule

// File: tb/tb_byte_bank_ctrl.sv
module tb_byte_bank_ctrl;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [7:0]        wdata_a = '0, wdata_b = '0;
  logic              gnt_a, gnt_b, ack_a, ack_b, busy;
  logic [7:0]        rdata_a, rdata_b, mem_data;
  logic [DEPTH-1:0]  mem_store;
  logic [8*DEPTH-1:0] mem_q;
  logic [2:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  byte_bank_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .ack_a(ack_a), .ack_b(ack_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .mem_data(mem_data), .mem_store(mem_store), .mem_q(mem_q),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- level-sensitive byte cell model ----------------
  logic [7:0] cells [DEPTH] = '{8'h10, 8'h11, 8'h12, 8'h13};

  always @(mem_store or mem_data) begin
    for (int i = 0; i < DEPTH; i++)
      if (mem_store[i]) cells[i] = mem_data;
  end

  always_comb begin
    mem_q = '0;
    for (int i = 0; i < DEPTH; i++) mem_q[8*i +: 8] = cells[i];
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    req_a = r; we_a = w; addr_a = a; wdata_a = d;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    req_b = r; we_b = w; addr_b = a; wdata_b = d;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    #12;
    checks++; if ({gnt_a, gnt_b, ack_a, ack_b, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {gnt_a, gnt_b, ack_a, ack_b, busy}); end
    checks++; if (mem_store !== 4'b0) begin errors++; $display("FAIL reset_store got %b exp 0000", mem_store); end
    checks++; if (mem_data !== 8'h00) begin errors++; $display("FAIL reset_mem_data got %h exp 00", mem_data); end
    checks++; if ({rdata_a, rdata_b} !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0000", {rdata_a, rdata_b}); end
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    @(negedge clk);
    reset = 1'b0;
    drive_a(1'b1, 1'b0, 2'd1, 8'h00);
    drive_b(1'b1, 1'b0, 2'd3, 8'h00);
    tick();
    checks++; if ({gnt_a, gnt_b} !== 2'b10) begin errors++; $display("FAIL first_tie got %b exp 10", {gnt_a, gnt_b}); end
    tick();
    checks++; if (ack_a !== 1'b1 || rdata_a !== 8'h11) begin errors++; $display("FAIL tie_read_a got ack %b rdata %h exp ack 1 rdata 11", ack_a, rdata_a); end
    req_a = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || gnt_b !== 1'b0) begin errors++; $display("FAIL tie_idle got busy %b gnt_b %b exp 0 0", busy, gnt_b); end
    tick();
    checks++; if (gnt_b !== 1'b1) begin errors++; $display("FAIL tie_gnt_b got %b exp 1", gnt_b); end
    tick();
    checks++; if (ack_b !== 1'b1 || rdata_b !== 8'h13 || rdata_a !== 8'h11) begin errors++; $display("FAIL tie_read_b got ack %b rdata_b %h rdata_a %h exp 1 13 11", ack_b, rdata_b, rdata_a); end
    req_b = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    logic [3:0] exp_store;
    logic [7:0] exp_data;
    drive_a(1'b1, 1'b1, 2'd2, 8'hA5);
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_store = (c == 2) ? 4'b0100 : 4'b0000;
      exp_data  = (c <= 3) ? 8'hA5 : 8'h00;
      checks++; if (mem_store !== exp_store) begin errors++; $display("FAIL wr_store c%0d got %b exp %b", c, mem_store, exp_store); end
      checks++; if (mem_data !== exp_data) begin errors++; $display("FAIL wr_data c%0d got %h exp %h", c, mem_data, exp_data); end
      checks++; if (ack_a !== (c == 4)) begin errors++; $display("FAIL wr_ack c%0d got %b exp %b", c, ack_a, (c == 4)); end
      checks++; if (gnt_a !== (c <= 4)) begin errors++; $display("FAIL wr_gnt c%0d got %b exp %b", c, gnt_a, (c <= 4)); end
      if (c == 4) req_a = 1'b0;
    end
    checks++; if (cells[2] !== 8'hA5 || busy !== 1'b0) begin errors++; $display("FAIL wr_cell got %h busy %b exp a5 0", cells[2], busy); end
  endtask

  task automatic test_read_back();
    drive_b(1'b1, 1'b0, 2'd2, 8'h00);
    tick();
    checks++; if (gnt_b !== 1'b1 || ack_b !== 1'b0) begin errors++; $display("FAIL rd_c1 got gnt %b ack %b exp 1 0", gnt_b, ack_b); end
    tick();
    checks++; if (ack_b !== 1'b1 || rdata_b !== 8'hA5) begin errors++; $display("FAIL rd_c2 got ack %b rdata %h exp 1 a5", ack_b, rdata_b); end
    checks++; if (rdata_a !== 8'h11) begin errors++; $display("FAIL rd_other got %h exp 11", rdata_a); end
    req_b = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || ack_b !== 1'b0) begin errors++; $display("FAIL rd_idle got busy %b ack %b exp 0 0", busy, ack_b); end
  endtask

  task automatic test_back_to_back();
    int grants = 0;
    int acks = 0;
    logic exp_b = 1'b0;
    logic pga = 1'b0, pgb = 1'b0, paa = 1'b0, pab = 1'b0;
    drive_a(1'b1, 1'b1, 2'd0, 8'h11);
    drive_b(1'b1, 1'b1, 2'd3, 8'h22);
    for (int c = 1; c <= 40 && acks < 4; c++) begin
      tick();
      checks++; if (gnt_a && gnt_b) begin errors++; $display("FAIL b2b_overlap c%0d got 11 exp not both", c); end
      if ((gnt_a && !pga) || (gnt_b && !pgb)) begin
        grants++;
        checks++; if (gnt_b !== exp_b) begin errors++; $display("FAIL b2b_order grant%0d got b=%b exp b=%b", grants, gnt_b, exp_b); end
        exp_b = ~exp_b;
      end
      if (ack_a || ack_b) begin
        acks++;
        checks++; if (c != 5 * acks - 1) begin errors++; $display("FAIL b2b_ack_cycle ack%0d got c%0d exp c%0d", acks, c, 5 * acks - 1); end
      end
      checks++; if ((ack_a && paa) || (ack_b && pab)) begin errors++; $display("FAIL b2b_ack_width c%0d got 2 cycles exp 1", c); end
      pga = gnt_a; pgb = gnt_b; paa = ack_a; pab = ack_b;
      if (acks == 4) begin req_a = 1'b0; req_b = 1'b0; end
    end
    checks++; if (acks != 4 || grants != 4) begin errors++; $display("FAIL b2b_count got acks %0d grants %0d exp 4 4", acks, grants); end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    checks++; if (cells[0] !== 8'h11 || cells[3] !== 8'h22) begin errors++; $display("FAIL b2b_cells got %h %h exp 11 22", cells[0], cells[3]); end
  endtask

  task automatic test_late_request();
    drive_a(1'b1, 1'b1, 2'd1, 8'h3C);
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 2) drive_b(1'b1, 1'b1, 2'd2, 8'h5A);
      checks++; if (gnt_b !== (c >= 6)) begin errors++; $display("FAIL late_gnt_b c%0d got %b exp %b", c, gnt_b, (c >= 6)); end
      checks++; if (ack_a !== (c == 4) || ack_b !== (c == 9)) begin errors++; $display("FAIL late_ack c%0d got %b%b exp %b%b", c, ack_a, ack_b, (c == 4), (c == 9)); end
      if (c == 4) req_a = 1'b0;
      if (c == 9) req_b = 1'b0;
    end
    tick();
    checks++; if (cells[1] !== 8'h3C || cells[2] !== 8'h5A) begin errors++; $display("FAIL late_cells got %h %h exp 3c 5a", cells[1], cells[2]); end
  endtask

  task automatic test_reset_strobe();
    logic [3:0] exp_store;
    drive_a(1'b1, 1'b1, 2'd3, 8'h77);
    tick();
    tick();
    checks++; if (mem_store !== 4'b1000) begin errors++; $display("FAIL rs_strobe got %b exp 1000", mem_store); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_store !== 4'b0000 || mem_data !== 8'h00) begin errors++; $display("FAIL rs_async got store %b data %h exp 0000 00", mem_store, mem_data); end
    checks++; if (busy !== 1'b0 || gnt_a !== 1'b0 || rdata_b !== 8'h00) begin errors++; $display("FAIL rs_ctrl got busy %b gnt %b rdata_b %h exp 0 0 00", busy, gnt_a, rdata_b); end
    checks++; if (cells[3] !== 8'h77) begin errors++; $display("FAIL rs_cell got %h exp 77", cells[3]); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (ack_a !== 1'b0) begin errors++; $display("FAIL rs_no_ack c%0d got %b exp 0", c, ack_a); end
    end
    @(negedge clk);
    reset = 1'b0;
    wdata_a = 8'h88;
    for (int c = 1; c <= 5; c++) begin
      tick();
      exp_store = (c == 2) ? 4'b1000 : 4'b0000;
      checks++; if (ack_a !== (c == 4) || mem_store !== exp_store) begin errors++; $display("FAIL rs_after c%0d got ack %b store %b exp %b %b", c, ack_a, mem_store, (c == 4), exp_store); end
      if (c == 4) req_a = 1'b0;
    end
    checks++; if (cells[3] !== 8'h88) begin errors++; $display("FAIL rs_after_cell got %h exp 88", cells[3]); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_back_to_back();
    test_late_request();
    test_reset_strobe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
